// File: rtl/seg7_scan_driver.sv
// Eight-digit common-anode 7-segment scan driver with blanking gaps and a frame-aligned
// double-buffered load. Optional decimal-point support is enabled by defining DISP_DP_EN.
module seg7_scan_driver #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        load_i,
    input  logic [31:0] digits_in_i,
    input  logic [7:0]  digit_en_i,
`ifdef DISP_DP_EN
    input  logic [7:0]  dp_in_i,
    output logic        dp_o,
`endif
    output logic        pending_o,
    output logic        frame_done_o,
    output logic [7:0]  an_o,
    output logic [6:0]  seg_o
);

    localparam int unsigned MaxCnt = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;
    localparam logic [CntW-1:0] ShowLast  = CntW'(REFRESH_DIV - 1);
    localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);

    typedef enum logic {StBlank, StShow} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      idx_q;

    logic [31:0] stage_dig_q, disp_dig_q;
    logic [7:0]  stage_en_q, disp_en_q;
    logic        pending_q;
    logic        frame_done_q;
    logic [7:0]  an_q;
    logic [6:0]  seg_q;

`ifdef DISP_DP_EN
    logic [7:0]  stage_dp_q, disp_dp_q;
    logic        dp_q;
`endif

    logic show_end;
    logic commit;

    // Hex to active-low gfedcba.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign show_end = (state_q == StShow) && (cnt_q == ShowLast);
    // Commit only on the wrap from digit 7 so a frame is never drawn from mixed data.
    assign commit   = show_end && (idx_q == 3'd7) && pending_q;

    // Scan FSM with registered pin outputs; pins follow the state by one cycle.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StBlank;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            an_q    <= 8'hFF;
            seg_q   <= 7'h7F;
`ifdef DISP_DP_EN
            dp_q    <= 1'b1;
`endif
        end else begin
            case (state_q)
                StBlank: begin
                    if (cnt_q == BlankLast) begin
                        state_q <= StShow;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StShow: begin
                    if (show_end) begin
                        state_q <= StBlank;
                        cnt_q   <= '0;
                        idx_q   <= idx_q + 3'd1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: begin
                    state_q <= StBlank;
                    cnt_q   <= '0;
                end
            endcase

            if ((state_q == StShow) && disp_en_q[idx_q]) begin
                an_q  <= ~(8'h01 << idx_q);
                seg_q <= seg_decode(disp_dig_q[{idx_q, 2'b00} +: 4]);
`ifdef DISP_DP_EN
                dp_q  <= ~disp_dp_q[idx_q];
`endif
            end else begin
                an_q  <= 8'hFF;
                seg_q <= 7'h7F;
`ifdef DISP_DP_EN
                dp_q  <= 1'b1;
`endif
            end
        end
    end

    // Staging and display buffers. A load coinciding with a commit lands in staging
    // after the old staged data has moved to the display.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stage_dig_q  <= '0;
            stage_en_q   <= '0;
            disp_dig_q   <= '0;
            disp_en_q    <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef DISP_DP_EN
            stage_dp_q   <= '0;
            disp_dp_q    <= '0;
`endif
        end else begin
            frame_done_q <= commit;
            pending_q    <= load_i | (pending_q & ~commit);
            if (commit) begin
                disp_dig_q <= stage_dig_q;
                disp_en_q  <= stage_en_q;
`ifdef DISP_DP_EN
                disp_dp_q  <= stage_dp_q;
`endif
            end
            if (load_i) begin
                stage_dig_q <= digits_in_i;
                stage_en_q  <= digit_en_i;
`ifdef DISP_DP_EN
                stage_dp_q  <= dp_in_i;
`endif
            end
        end
    end

    assign pending_o    = pending_q;
    assign frame_done_o = frame_done_q;
    assign an_o         = an_q;
    assign seg_o        = seg_q;
`ifdef DISP_DP_EN
    assign dp_o         = dp_q;
`endif

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV=4, BLANK_CYCLES=2 (48-cycle frame).
// Each table row describes one frame: what it should show and which loads happen during it.
module tb_seg7_scan_driver;

    localparam int Frame = 48;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic [31:0] digits = '0;
    logic [7:0]  den = '0;
    logic        pending;
    logic        frame_done;
    logic [7:0]  an;
    logic [6:0]  seg;
`ifdef DISP_DP_EN
    logic [7:0]  dp_in = '0;
    logic        dp;
`endif

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .REFRESH_DIV (4),
        .BLANK_CYCLES(2)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .load_i      (load),
        .digits_in_i (digits),
        .digit_en_i  (den),
`ifdef DISP_DP_EN
        .dp_in_i     (dp_in),
        .dp_o        (dp),
`endif
        .pending_o   (pending),
        .frame_done_o(frame_done),
        .an_o        (an),
        .seg_o       (seg)
    );

    typedef struct {
        logic [7:0][6:0] segs;  // expected seg per digit shown this frame
        logic [7:0]      en;    // expected enables shown this frame
        int              t1;    // tick of first load (0 = none)
        logic [31:0]     d1;
        logic [7:0]      e1;
        int              t2;    // tick of second load (0 = none)
        logic [31:0]     d2;
        logic [7:0]      e2;
        logic            fd;    // frame_done expected at the end of this frame
    } frame_t;

    int     n_tests = 0;
    int     n_fail  = 0;
    int     cyc     = 0;
    logic   pend_exp = 1'b0;
    frame_t frames[11];

    function automatic frame_t mk(input logic [7:0][6:0] segs, input logic [7:0] en,
                                  input int t1, input logic [31:0] d1, input logic [7:0] e1,
                                  input int t2, input logic [31:0] d2, input logic [7:0] e2,
                                  input logic fd);
        frame_t f;
        f.segs = segs; f.en = en;
        f.t1 = t1; f.d1 = d1; f.e1 = e1;
        f.t2 = t2; f.d2 = d2; f.e2 = e2;
        f.fd = fd;
        return f;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Pins after edge k reflect the scan state after edge k-1.
    task automatic check_pins(input logic [7:0][6:0] segs, input logic [7:0] en);
        int q, idx, p;
        logic [7:0] exp_an;
        q   = (cyc - 1) % Frame;
        idx = q / 6;
        p   = q % 6;
        if (p < 2) begin
            check("an_blank", an, 8'hFF);
            check("seg_blank", seg, 7'h7F);
        end else if (en[idx]) begin
            exp_an = ~(8'h01 << idx);
            check("an_show", an, exp_an);
            check("seg_show", seg, segs[idx]);
        end else begin
            check("an_off", an, 8'hFF);
        end
    endtask

    task automatic run_frame(input frame_t f);
        logic ld;
        for (int t = 1; t <= Frame; t++) begin
            ld = 1'b0;
            if (t == f.t1) begin
                load = 1'b1; digits = f.d1; den = f.e1; ld = 1'b1;
            end else if (t == f.t2) begin
                load = 1'b1; digits = f.d2; den = f.e2; ld = 1'b1;
            end
            tick();
            load = 1'b0;
            if (ld) pend_exp = 1'b1;
            else if (t == Frame && f.fd) pend_exp = 1'b0;
            check_pins(f.segs, f.en);
            check("frame_done", frame_done, (t == Frame) && f.fd);
            check("pending", pending, pend_exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        frames[0]  = mk('0, 8'h00, 0, '0, '0, 0, '0, '0, 1'b0);
        frames[1]  = mk('0, 8'h00, 0, '0, '0, 0, '0, '0, 1'b0);
        frames[2]  = mk('0, 8'h00, 10, 32'h76543210, 8'hFF, 0, '0, '0, 1'b1);
        frames[3]  = mk({7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40}, 8'hFF,
                        10, 32'h11111111, 8'hFF, 20, 32'hAAAAAAAA, 8'hFF, 1'b1);
        frames[4]  = mk({8{7'h08}}, 8'hFF, 10, 32'hFFFFFFFF, 8'h05, 0, '0, '0, 1'b1);
        frames[5]  = mk({8{7'h0E}}, 8'h05, 10, 32'hFEDCBA98, 8'hFF, 0, '0, '0, 1'b1);
        // Second load lands on the commit edge itself.
        frames[6]  = mk({7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00}, 8'hFF,
                        10, 32'hCCCCCCCC, 8'hFF, 48, 32'h33333333, 8'hFF, 1'b1);
        frames[7]  = mk({8{7'h46}}, 8'hFF, 0, '0, '0, 0, '0, '0, 1'b1);
        frames[8]  = mk({8{7'h30}}, 8'hFF, 0, '0, '0, 0, '0, '0, 1'b0);
        // After the mid-scan reset: cleared display, then the new load.
        frames[9]  = mk('0, 8'h00, 10, 32'h13579BDF, 8'hAA, 0, '0, '0, 1'b1);
        frames[10] = mk({7'h79, 7'h30, 7'h12, 7'h78, 7'h10, 7'h03, 7'h21, 7'h0E}, 8'hAA,
                        0, '0, '0, 0, '0, '0, 1'b0);

        #1 reset = 1'b1;
        #2;
        check("rst_an", an, 8'hFF);
        check("rst_seg", seg, 7'h7F);
        check("rst_pending", pending, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        cyc = 0;

        for (int i = 0; i <= 8; i++) run_frame(frames[i]);

        // Stage data, then reset while digit 3 of the 0x33333333 frame is lit.
        for (int t = 1; t <= 22; t++) begin
            load = (t == 5);
            digits = 32'h55555555;
            den = 8'hFF;
            tick();
        end
        load = 1'b0;
        check("pre_rst_an", an, 8'hF7);
        check("pre_rst_seg", seg, 7'h30);
        check("pre_rst_pending", pending, 1'b1);
        reset = 1'b1;
        #1;
        check("async_rst_an", an, 8'hFF);
        check("async_rst_seg", seg, 7'h7F);
        check("async_rst_pending", pending, 1'b0);
        check("async_rst_frame_done", frame_done, 1'b0);
        @(posedge clk);
        #1;
        check("held_rst_an", an, 8'hFF);
        reset = 1'b0;
        cyc = 0;
        pend_exp = 1'b0;

        run_frame(frames[9]);
        run_frame(frames[10]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
